imem_responder: RTL and testbench

- Responder end of the fetch-to-instruction-memory request/ack interface.
- Accepts word-fetch requests (addr, req, req_kill, icache_flush) and returns ack and r_data after a programmable latency, from a local word-addressed instruction store.
- Serves as the instruction-side memory model for core bring-up and fetch/C-extension verification, and as the template for the future icache miss path.
- Also models the redirect-kill and flush timing that fetch must tolerate.

---
 rtl/imem_responder.sv | 153 +++++++++++++++
 tb/tb_imem_responder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// imem_responder
//   Responder side of the fetch-to-instruction-memory request/ack interface.
//   It accepts word fetches, returns the addressed word from a local
//   word-addressed store after LATENCY cycles, and models redirect-kill and
//   icache-flush timing. A side loader port fills the store.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   req_i           level fetch request
//   addr_i          byte address, bits [1:0] ignored
//   req_kill_i      drop the in-flight request (redirect)
//   icache_flush_i  flush command, busy for FLUSH_CYCLES cycles
//   ack_o           one-cycle response pulse per accepted request
//   r_data_o        fetched word (NOP when out of range), held between acks
//   fault_o         address outside the mapped window, valid with ack_o
//   busy_o          request in flight or flush in progress
//   ld_we_i, ld_addr_i, ld_data_i   loader write port
module imem_responder #(
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned LATENCY      = 1,
    parameter int unsigned FLUSH_CYCLES = 4,
    parameter logic [31:0] BASE_ADDR    = 32'h8000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_i,
    input  logic [31:0]              addr_i,
    input  logic                     req_kill_i,
    input  logic                     icache_flush_i,
    output logic                     ack_o,
    output logic [31:0]              r_data_o,
    output logic                     fault_o,
    output logic                     busy_o,
    input  logic                     ld_we_i,
    input  logic [$clog2(DEPTH)-1:0] ld_addr_i,
    input  logic [31:0]              ld_data_i
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    // The expiry cycle registers ack for the following cycle, so the wait
    // counter is loaded with LATENCY-2 to land ack exactly LATENCY cycles
    // after acceptance. With LATENCY=1 the accept cycle is itself the
    // expiry cycle and WAIT is never entered.
    localparam logic [3:0] LAT_LOAD   = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    logic [31:0]   mem [DEPTH];

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic [AW-1:0] idx_q;
    logic          oor_q;

    logic [31:0]   off;
    logic [AW-1:0] new_idx;
    logic          new_oor;
    logic          expire;
    logic          accept;
    logic          fire;
    logic [AW-1:0] rd_idx;
    logic          rd_oor;

    // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
    assign off     = addr_i - BASE_ADDR;
    assign new_idx = off[AW+1:2];
    assign new_oor = (off >> (AW + 2)) != 32'd0;

    always_comb begin
        expire = 1'b0;
        accept = 1'b0;
        fire   = 1'b0;
        rd_idx = idx_q;
        rd_oor = oor_q;
        expire = (state == S_WAIT) && (cnt == 4'd0) && !req_kill_i && !icache_flush_i;
        accept = req_i && !req_kill_i && !icache_flush_i &&
                 ((state == S_IDLE) || expire);
        if (LATENCY == 1) begin
            fire   = accept;
            rd_idx = new_idx;
            rd_oor = new_oor;
        end else begin
            fire   = expire;
        end
    end

    assign busy_o = (state != S_IDLE);

    // Loader writes land at the same edge as the response read, so a
    // colliding read returns the old word.
    always_ff @(posedge clk) begin
        if (ld_we_i) begin
            mem[ld_addr_i] <= ld_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            idx_q    <= '0;
            oor_q    <= 1'b0;
            ack_o    <= 1'b0;
            r_data_o <= NOP;
            fault_o  <= 1'b0;
        end else begin
            ack_o <= fire;
            if (fire) begin
                r_data_o <= rd_oor ? NOP : mem[rd_idx];
                fault_o  <= rd_oor;
            end

            if (icache_flush_i) begin
                state <= S_FLUSH;
                cnt   <= FLUSH_LOAD;
            end else if (accept && (LATENCY > 1)) begin
                state <= S_WAIT;
                cnt   <= LAT_LOAD;
                idx_q <= new_idx;
                oor_q <= new_oor;
            end else begin
                case (state)
                    S_WAIT: begin
                        if (req_kill_i || (cnt == 4'd0)) begin
                            state <= S_IDLE;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    S_FLUSH: begin
                        if (cnt == 4'd0) begin
                            state <= S_IDLE;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    S_IDLE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: two instances (LATENCY=1 and LATENCY=3) share
// randomized stimulus. Each instance has a timestamp-based reference model
// that pushes expected acks into a queue, and a monitor that pops and
// compares whenever the DUT raises ack_o.
module tb_imem_responder;

    localparam int unsigned DEPTH        = 1024;
    localparam int unsigned FLUSH_CYCLES = 4;
    localparam int          AW           = 10;
    localparam logic [31:0] BASE         = 32'h8000_0000;
    localparam logic [31:0] NOP          = 32'h0000_0013;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          req     = 1'b0;
    logic [31:0]   addr    = '0;
    logic          kill    = 1'b0;
    logic          flush   = 1'b0;
    logic          ld_we   = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [31:0]   ld_data = '0;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        fault;
    } exp_t;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned LAT = (g == 0) ? 1 : 3;

        logic        ack;
        logic        fault;
        logic        busy;
        logic [31:0] rdata;

        imem_responder #(
            .DEPTH       (DEPTH),
            .LATENCY     (LAT),
            .FLUSH_CYCLES(FLUSH_CYCLES),
            .BASE_ADDR   (BASE)
        ) u_dut (
            .clk           (clk),
            .rst           (rst),
            .req_i         (req),
            .addr_i        (addr),
            .req_kill_i    (kill),
            .icache_flush_i(flush),
            .ack_o         (ack),
            .r_data_o      (rdata),
            .fault_o       (fault),
            .busy_o        (busy),
            .ld_we_i       (ld_we),
            .ld_addr_i     (ld_addr),
            .ld_data_i     (ld_data)
        );

        exp_t        sb[$];
        logic [31:0] mm [DEPTH];
        int          due       = -1;   // cycle the pending ack is due, -1 = none
        int          flush_end = -1;   // last busy cycle of the current flush
        int unsigned p_idx     = 0;
        bit          p_oor     = 1'b0;
        logic [31:0] exp_rdata = NOP;
        bit          exp_busy  = 1'b0;

        function automatic void push(int c, int unsigned i, bit o);
            exp_t e;
            e.cyc   = c;
            e.data  = o ? NOP : mm[i];
            e.fault = o;
            sb.push_back(e);
            exp_rdata = e.data;
        endfunction

        // Reference: a request accepted in cycle T is acked in T+LAT; the
        // word is read in cycle T+LAT-1, before that cycle's loader write.
        always @(posedge clk) begin : model
            logic [31:0] off;
            bit          oor;
            int unsigned idx;
            off = addr - BASE;
            oor = (off >= 4 * DEPTH);
            idx = off / 4;
            if (rst) begin
                due       = -1;
                flush_end = -1;
                exp_rdata = NOP;
            end else if (flush) begin
                due       = -1;
                flush_end = cyc + FLUSH_CYCLES;
            end else if (cyc <= flush_end) begin
                due = -1;
            end else if (kill) begin
                due = -1;
            end else begin
                if (due >= 0 && cyc == due - 1) begin
                    push(cyc + 1, p_idx, p_oor);
                    due = -1;
                end
                if (due < 0 && req) begin
                    if (LAT == 1) begin
                        push(cyc + 1, oor ? 0 : idx, oor);
                    end else begin
                        due   = cyc + LAT;
                        p_idx = oor ? 0 : idx;
                        p_oor = oor;
                    end
                end
            end
            if (ld_we) mm[ld_addr] = ld_data;
            exp_busy = (due >= 0) || (cyc + 1 <= flush_end);
        end

        always @(negedge clk) begin : monitor
            exp_t e;
            if (chk_en) begin
                checks++;
                if (busy !== exp_busy) begin
                    failures++;
                    $display("FAIL busy L%0d cyc=%0d got=%b exp=%b", LAT, cyc, busy, exp_busy);
                end
                checks++;
                if (rdata !== exp_rdata) begin
                    failures++;
                    $display("FAIL r_data L%0d cyc=%0d got=%h exp=%h", LAT, cyc, rdata, exp_rdata);
                end
                checks++;
                if (ack === 1'b1) begin
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL spurious_ack L%0d cyc=%0d got=1 exp=0", LAT, cyc);
                    end else begin
                        e = sb.pop_front();
                        if (e.cyc != cyc || e.data !== rdata || e.fault !== fault) begin
                            failures++;
                            $display("FAIL ack L%0d cyc=%0d got(data=%h fault=%b) exp(cyc=%0d data=%h fault=%b)",
                                     LAT, cyc, rdata, fault, e.cyc, e.data, e.fault);
                        end
                    end
                end else begin
                    if (ack !== 1'b0 || (sb.size() > 0 && sb[0].cyc <= cyc)) begin
                        failures++;
                        $display("FAIL missing_ack L%0d cyc=%0d got=%b exp=1", LAT, cyc, ack);
                        if (sb.size() > 0) void'(sb.pop_front());
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [31:0] pick_addr();
        int unsigned s;
        s = $urandom_range(0, 9);
        case (s)
            6:       return BASE + 32'h0000_0FFC;
            7:       return BASE + 32'h0000_1000;
            8:       return 32'h7FFF_FFFC;
            9:       return $urandom() | 32'h0001_0000;
            default: return BASE + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
        endcase
    endfunction

    function automatic logic [AW-1:0] pick_ld();
        int unsigned s;
        s = $urandom_range(0, 16);
        if (s == 16) return '1;
        return s[AW-1:0];
    endfunction

    initial begin
        // Two reset cycles; checking starts once reset has been sampled.
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;

        // Preload words 0..15 and the last word.
        for (int i = 0; i <= 16; i++) begin
            ld_we   = 1'b1;
            ld_addr = (i < 16) ? i[AW-1:0] : '1;
            ld_data = (i == 0) ? 32'h0050_0093 : $urandom();
            tick();
        end
        ld_we = 1'b0;
        tick();
        tick();

        // Single fetch of word 0.
        req  = 1'b1;
        addr = BASE;
        tick();
        req = 1'b0;
        repeat (6) tick();

        // Randomized traffic.
        repeat (4000) begin
            rst     = ($urandom_range(0, 199) == 0);
            req     = ($urandom_range(0, 3) != 0);
            kill    = ($urandom_range(0, 15) == 0);
            flush   = ($urandom_range(0, 39) == 0);
            addr    = pick_addr();
            ld_we   = ($urandom_range(0, 3) == 0);
            ld_addr = pick_ld();
            ld_data = $urandom();
            tick();
        end

        rst   = 1'b0;
        req   = 1'b0;
        kill  = 1'b0;
        flush = 1'b0;
        ld_we = 1'b0;
        repeat (12) tick();

        checks++;
        if (g_dut[0].sb.size() != 0) begin
            failures++;
            $display("FAIL drain L1 got=%0d pending exp=0", g_dut[0].sb.size());
        end
        checks++;
        if (g_dut[1].sb.size() != 0) begin
            failures++;
            $display("FAIL drain L3 got=%0d pending exp=0", g_dut[1].sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
